// File: rtl/max_q_seq_fp_pkg.sv
// Shared definitions for the max/argmax Q-value reducer.
//   FP_W, EXP_MSB, EXP_LSB, SIGN_BIT : IEEE-754 single-precision field positions
//   FP_ZERO                          : all-zero word (+0.0)
//   state_t                          : reducer state (IDLE, ACCUM)
package max_q_seq_fp_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;

    localparam logic [FP_W-1:0] FP_ZERO = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/max_q_seq_fp_if.sv
// Beat/result bundle between the Q-table read port and the max reducer.
//   i_clear  : abort partial vector
//   i_valid  : i_data carries a Q-value (no backpressure)
//   i_data   : Q-value, IEEE-754 single precision
//   o_max    : maximum of the last completed vector
//   o_idx    : action index of o_max
//   o_valid  : one-cycle pulse, o_max/o_idx are new
//   o_busy   : partial vector held
// master drives the beats, slave is the reducer.
interface max_q_seq_fp_if #(
    parameter int IDX_W = 2
);

    logic                               i_clear;
    logic                               i_valid;
    logic [max_q_seq_fp_pkg::FP_W-1:0]  i_data;
    logic [max_q_seq_fp_pkg::FP_W-1:0]  o_max;
    logic [IDX_W-1:0]                   o_idx;
    logic                               o_valid;
    logic                               o_busy;

    modport master (
        output i_clear,
        output i_valid,
        output i_data,
        input  o_max,
        input  o_idx,
        input  o_valid,
        input  o_busy
    );

    modport slave (
        input  i_clear,
        input  i_valid,
        input  i_data,
        output o_max,
        output o_idx,
        output o_valid,
        output o_busy
    );

endinterface

// File: rtl/max_q_seq_fp_fp_gt_cmp.sv
// Combinational IEEE-754 single-precision "a strictly greater than b".
//   a, b : operands
//   gt   : 1 when a > b
// +0 and -0 compare equal. A NaN on either side never yields gt, so a NaN
// already held as the running max is never displaced.
module fp_gt_cmp
    import max_q_seq_fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt
);

    logic [EXP_MSB:0] a_mag;
    logic [EXP_MSB:0] b_mag;
    logic             a_nan;
    logic             b_nan;

    always_comb begin
        a_mag = a[EXP_MSB:0];
        b_mag = b[EXP_MSB:0];
        a_nan = (a[EXP_MSB:EXP_LSB] == '1) && (a[EXP_LSB-1:0] != '0);
        b_nan = (b[EXP_MSB:EXP_LSB] == '1) && (b[EXP_LSB-1:0] != '0);
        gt    = 1'b0;
        if (a_nan || b_nan) begin
            gt = 1'b0;
        end else if ((a_mag == '0) && (b_mag == '0)) begin
            gt = 1'b0;
        end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            gt = ~a[SIGN_BIT];
        end else if (!a[SIGN_BIT]) begin
            gt = (a_mag > b_mag);
        end else begin
            // both negative: smaller magnitude is the larger value
            gt = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/max_q_seq_fp.sv
// Sequential max/argmax reducer over the NUM_ACTIONS Q-values of one state.
// Accepts one Q-value per valid beat (action order 0..NUM_ACTIONS-1) and
// emits a registered max/index with a one-cycle o_valid pulse one cycle
// after the last beat of each vector.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of max_q_seq_fp_if (beats in, result/status out)
// Parameters:
//   NUM_ACTIONS : Q-values per vector, 1..16
//   IDX_W       : action index width, max(1, ceil(log2(NUM_ACTIONS)))
module max_q_seq_fp
    import max_q_seq_fp_pkg::*;
#(
    parameter int NUM_ACTIONS = 4,
    parameter int IDX_W       = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    max_q_seq_fp_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACTIONS - 1);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [FP_W-1:0]   run_max;
    logic [IDX_W-1:0]  run_idx;
    logic [FP_W-1:0]   max_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;

    logic              cand_gt;
    logic [FP_W-1:0]   next_max;
    logic [IDX_W-1:0]  next_idx;

    fp_gt_cmp u_gt (
        .a  (bus.i_data),
        .b  (run_max),
        .gt (cand_gt)
    );

    // Ties keep the earlier element: only a strict win replaces it.
    always_comb begin
        next_max = run_max;
        next_idx = run_idx;
        if (cand_gt) begin
            next_max = bus.i_data;
            next_idx = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            run_max <= FP_ZERO;
            run_idx <= '0;
            max_q   <= FP_ZERO;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.i_clear) begin
                // Drops any beat in this cycle; result registers untouched.
                state <= IDLE;
                cnt   <= '0;
            end else if (bus.i_valid) begin
                case (state)
                    IDLE: begin
                        if (NUM_ACTIONS == 1) begin
                            max_q   <= bus.i_data;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            run_max <= bus.i_data;
                            run_idx <= '0;
                            cnt     <= IDX_W'(1);
                            state   <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (cnt == LAST_IDX) begin
                            max_q   <= next_max;
                            idx_q   <= next_idx;
                            valid_q <= 1'b1;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            run_max <= next_max;
                            run_idx <= next_idx;
                            cnt     <= cnt + IDX_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_max   = max_q;
    assign bus.o_idx   = idx_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = (state == ACCUM);

endmodule

// File: tb/tb_max_q_seq_fp.sv
// Directed bench for max_q_seq_fp (NUM_ACTIONS=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_max_q_seq_fp;

    typedef logic [31:0] vec_t [4];

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_pulses;

    max_q_seq_fp_if #(.IDX_W(2)) bus ();

    max_q_seq_fp #(
        .NUM_ACTIONS (4),
        .IDX_W       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result pulses 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.o_valid) n_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Order key: negatives below zeros below positives; both zeros equal.
    function automatic logic [32:0] order_key(input logic [31:0] x);
        if (x[30:0] == 31'd0) return {1'b1, 32'h0};
        if (!x[31])           return {1'b1, 1'b0, x[30:0]};
        return {1'b0, 1'b0, ~x[30:0]};
    endfunction

    function automatic int ref_idx(input vec_t v);
        int best = 0;
        for (int i = 1; i < 4; i++)
            if (order_key(v[i]) > order_key(v[best])) best = i;
        return best;
    endfunction

    // Sends one vector starting from IDLE with 'gap' idle cycles between
    // beats; returns at the falling edge after the last beat was accepted.
    task automatic send_vec(input string tag, input vec_t v, input int gap);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_busy_pre"}, 32'(bus.o_busy), (k == 0) ? 32'd0 : 32'd1);
            bus.i_valid = 1'b1;
            bus.i_data  = v[k];
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.i_valid = 1'b0;
                    check({tag, "_busy_gap"}, 32'(bus.o_busy), 32'd1);
                end
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        check({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] emax, input logic [31:0] eidx);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_max"}, bus.o_max, emax);
        check({tag, "_idx"}, 32'(bus.o_idx), eidx);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t va;
        vec_t vb;
        int   p0;

        n_checks    = 0;
        n_errors    = 0;
        n_pulses    = 0;
        rst_n       = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_max", bus.o_max, 32'h0);
        check("rst_idx", 32'(bus.o_idx), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;

        // Mixed signs, consecutive beats.
        v = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000};
        send_vec("basic", v, 0);
        expect_result("basic", 32'h40000000, 32'd1);

        // All negative, 2-cycle gaps.
        v = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0800000};
        send_vec("neg", v, 2);
        expect_result("neg", 32'hBF000000, 32'd1);

        // Signed zeros tie; earliest wins.
        v = '{32'h80000000, 32'h00000000, 32'h80000000, 32'hBF800000};
        send_vec("zero", v, 0);
        expect_result("zero", 32'h80000000, 32'd0);

        // All equal.
        v = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_vec("tie", v, 1);
        expect_result("tie", 32'h3F800000, 32'd0);

        // Abort: two beats, clear with a third beat, then a full vector.
        p0 = n_pulses;
        @(negedge clk); bus.i_valid = 1'b1; bus.i_data = 32'h3F800000;
        @(negedge clk); bus.i_data = 32'h40000000;
        @(negedge clk); bus.i_clear = 1'b1; bus.i_data = 32'h41000000;
        @(negedge clk); bus.i_clear = 1'b0; bus.i_valid = 1'b0;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_max_hold", bus.o_max, 32'h3F800000);
        v = '{32'h3F000000, 32'h3F800000, 32'h40400000, 32'h40000000};
        send_vec("abort", v, 0);
        expect_result("abort", 32'h40400000, 32'd2);
        check("abort_pulses", 32'(n_pulses - p0), 32'd1);

        // Back-to-back: eight consecutive beats, two vectors.
        va = '{32'h40A00000, 32'hC0A00000, 32'h40A00000, 32'h41000000};
        vb = '{32'hC1200000, 32'hBF800000, 32'h00000000, 32'h80000000};
        p0 = n_pulses;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                check("b2b_a_valid", 32'(bus.o_valid), 32'd1);
                check("b2b_a_max", bus.o_max, va[ref_idx(va)]);
                check("b2b_a_idx", 32'(bus.o_idx), 32'(ref_idx(va)));
            end else if (k > 0) begin
                check("b2b_gap_valid", 32'(bus.o_valid), 32'd0);
            end
            bus.i_valid = 1'b1;
            bus.i_data  = (k < 4) ? va[k] : vb[k-4];
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        expect_result("b2b_b", vb[ref_idx(vb)], 32'(ref_idx(vb)));
        check("b2b_pulses", 32'(n_pulses - p0), 32'd2);

        // Asynchronous reset between edges mid-vector.
        @(negedge clk); bus.i_valid = 1'b1; bus.i_data = 32'h42000000;
        @(negedge clk); bus.i_data = 32'h42800000;
        @(negedge clk); bus.i_valid = 1'b0;
        p0 = n_pulses;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_max", bus.o_max, 32'h0);
        check("arst_idx", 32'(bus.o_idx), 32'd0);
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_no_pulse", 32'(n_pulses - p0), 32'd0);
        v = '{32'h3F000000, 32'h3F800000, 32'h40400000, 32'h40000000};
        send_vec("post_rst", v, 0);
        expect_result("post_rst", 32'h40400000, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/max_q_seq_fp.md
Name: max_q_seq_fp

Overview:
- Sequential max/argmax reducer over the NUM_ACTIONS IEEE-754 single-precision Q-values of one state.
- Sits directly downstream of the Q-table read port and feeds the Bellman-update adder with max_a' Q(s',a'). It also outputs the winning action index for greedy action selection.
- Consumes one Q-value per accepted beat. Emits one registered result pulse per completed vector.

Parameters:
- NUM_ACTIONS, 4, number of Q-values per vector; legal range 1..16.
- IDX_W, 2, width of the action index; must equal max(1, ceil(log2(NUM_ACTIONS))).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous abort of any partial vector.
- i_valid  input  1  i_data is valid this cycle; no backpressure, so every valid beat is accepted.
- i_data  input  32  Q-value, IEEE-754 single precision; element order is action 0..NUM_ACTIONS-1.
- o_max  output  32  maximum Q-value of the last completed vector.
- o_idx  output  IDX_W  index of o_max within that vector.
- o_valid  output  1  one-cycle pulse: o_max and o_idx are new.
- o_busy  output  1  high while a partial vector is held.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, element counter=0, running max=0, running index=0, o_max=32'h0, o_idx=0, o_valid=0, o_busy=0.
- State machine states: IDLE and ACCUM. o_busy = (state==ACCUM).
- IDLE with i_valid:
  - Load i_data as the running max, running index=0, counter=1.
  - Go to ACCUM.
  - If NUM_ACTIONS==1, complete immediately instead and stay in IDLE.
- ACCUM with i_valid:
  - Compare i_data against the running max; replace it only if i_data is strictly greater. Replace the index with the counter value.
  - Increment the counter.
  - When the accepted beat is element NUM_ACTIONS-1, complete and return to IDLE with counter=0.
- Cycles with i_valid low: hold all state. Gaps between beats are allowed and do not change the result.
- Completion:
  - The final compare result is registered into o_max and o_idx.
  - o_valid=1 in the cycle after the last beat is accepted, for exactly one cycle.
  - o_max and o_idx hold their values until the next completion.
- Latency: 1 cycle from the last accepted beat to o_valid.
- Back-to-back vectors: element 0 of the next vector may arrive in the same cycle o_valid is high. It is accepted with no bubble.
- i_clear:
  - Forces IDLE and counter=0, and discards the partial vector; no o_valid is produced for it.
  - It has priority over i_valid in the same cycle, so that beat is dropped.
  - It does not alter o_max or o_idx.
  - It does not suppress an o_valid already scheduled from the previous cycle's completion.
- Comparison rule (a greater than b):
  - If both magnitudes (bits 30:0) are zero, the result is false, so +0 == -0.
  - If signs differ, the result is true when a is positive.
  - If both are positive, compare magnitudes as unsigned integers, a > b.
  - If both are negative, the result is true when a's magnitude < b's.
- NaN (exp=8'hFF, mantissa!=0) is never greater than anything and is never displaced from the first position only if it is element 0. NaN input is outside the normal operating contract.
- Ties keep the earliest index.
- Reset mid-vector: all state clears immediately and no o_valid follows.

Decomposition:
- Shared package holds:
  - FP_W=32, EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31;
  - the FP_ZERO constant;
  - the state enumeration type (IDLE, ACCUM).
- One combinational sub-module, fp_gt_cmp (inputs a, b; output gt), implements the comparison rule. It is reusable by the epsilon-greedy selector.

Test Plan:
- Beats 3F800000, 40000000, C0400000, 3F000000 on consecutive cycles -> one cycle after the 4th beat, o_valid=1, o_max=40000000, o_idx=1.
- All-negative beats BF800000, BF000000, C0000000, C0800000, with 2-cycle gaps between beats -> o_max=BF000000, o_idx=1. o_busy stays high from beat 1 until the cycle of the 4th beat.
- Ties and signed zeros:
  - Beats 80000000, 00000000, 80000000, BF800000 -> o_max=80000000, o_idx=0.
  - Beats 3F800000 x4 -> o_idx=0.
- Abort: two beats, then i_clear together with a third beat, then a full vector 3F000000, 3F800000, 40400000, 40000000 -> exactly one o_valid, with o_max=40400000, o_idx=2.
- Back-to-back: two vectors in 8 consecutive cycles -> o_valid on cycles 5 and 9, with no lost beat. Results match a per-vector reference model.
- Asynchronous reset asserted mid-vector, between clock edges -> all outputs clear immediately. A following full vector produces a correct result.
